control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus computer.
- Steps through fetch and execute T-states and drives every datapath control line: the memory address-register load (MI), the memory write (WE), and the register, ALU, program counter and output enables.
- Decodes the opcode (upper nibble of the instruction register) together with the carry and zero flags.
- Owns the halt state.

Parameters:
- OP_W, 4, opcode width (instruction bits [7:4]).
- STEP_W, 3, T-state counter width; T0..T4 used.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset.
- run  in  1  step enable; 0 freezes the step counter with controls still decoded.
- opcode  in  4  instruction register [7:4].
- carry_flag  in  1  latched ALU carry.
- zero_flag  in  1  latched ALU zero.
- ctrl  out  16  control word: bit order per package (HLT, MI, WE, RO, IO, II, AI, AO, EO, SU, BI, OI, CE, CO, J, FI).
- step  out  3  current T-state, for debug display.
- halted  out  1  high once HLT has executed.

Behaviour:
- Reset (rst low, async):
  - step=0, halted=0, ctrl=0 while rst is low.
  - After release, T0 decode appears in the same cycle.
- ctrl is a combinational decode of the registered step and halted state plus the live opcode/flags. The datapath samples it on the next posedge.
- Fetch, common to all opcodes:
  - T0: MI CO.
  - T1: RO II CE.
- Execute, T2 onward:
  - NOP 0000: none.
  - LDA 0001: T2 IO MI; T3 RO AI.
  - ADD 0010: T2 IO MI; T3 RO BI; T4 EO AI FI.
  - SUB 0011: as ADD, plus SU at T4.
  - STA 0100: T2 IO MI; T3 AO WE.
  - LDI 0101: T2 IO AI.
  - JMP 0110: T2 IO J.
  - JC 0111: T2 IO J if carry_flag=1, else none.
  - JZ 1000: T2 IO J if zero_flag=1, else none.
  - OUT 1110: T2 AO OI.
  - HLT 1111: T2 HLT.
  - 1001–1101: treated as NOP.
- Step advance, on posedge with run=1:
  - step returns to 0 after the last active step of the current opcode: NOP, LDI, JMP, JC/JZ taken or not, OUT and undefined opcodes end after T2; LDA and STA after T3; ADD and SUB after T4.
  - No idle T-states are spent.
- run=0: step and halted hold; ctrl keeps the current decode.
- Halt:
  - At the posedge ending a T2 with HLT active, halted goes to 1 and step goes to 0.
  - While halted, ctrl=0 except bit HLT=1; run is ignored.
  - Only reset clears halted.
- Flags are sampled combinationally only at T2 of JC/JZ; flag changes at other steps have no effect.
- Reset mid-instruction: an immediate return to T0/not-halted is required, with no partial write. WE is deasserted asynchronously with rst.
- step never exceeds 4. An illegal step value (3'b101–111) forces step to 0 on the next edge with ctrl=0.

Decomposition:
- Shared package:
  - Opcode localparams (OP_NOP…OP_HLT).
  - Control-word bit indices (CTRL_HLT…CTRL_FI).
  - CTRL_W=16.
  - Per-opcode last-step constants.
- One natural sub-module: microcode_rom, a purely combinational {opcode, step, carry, zero} -> {ctrl, last_step} lookup.
- control_sequencer keeps the step register, halted flag, run gating and reset forcing.

Test Plan:
- Reset: hold rst=0 for 3 cycles with opcode=0010 -> ctrl=0, step=0, halted=0. Release -> T0 ctrl has exactly MI and CO.
- LDA: opcode=0001, run=1 -> 4-cycle sequence MI|CO, RO|II|CE, IO|MI, RO|AI, then step=0.
- ADD then SUB:
  - ADD -> 5 cycles; T4 = EO|AI|FI with SU=0.
  - SUB -> T4 = EO|AI|SU|FI.
  - STA T3 = AO|WE.
- Conditional jump:
  - JC with carry=1 -> T2 = IO|J.
  - JC with carry=0 -> T2 ctrl=0, step returns to 0 after 3 cycles.
  - JZ likewise with zero_flag.
- Halt: opcode=1111 -> after T2 edge halted=1, ctrl=HLT only. Toggling run and opcode for 10 cycles changes nothing. rst pulse -> halted=0.
- Freeze and mid-reset:
  - run=0 at T3 of ADD for 4 cycles -> step=3, ctrl constant.
  - Assert rst at T3 of STA -> WE drops immediately, step=0 after release.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared opcodes, control-word bit positions and T-state encoding for the
// bus-computer control sequencer.
package control_sequencer_pkg;

   localparam int OP_W   = 4;
   localparam int STEP_W = 3;
   localparam int CTRL_W = 16;

   localparam logic [OP_W-1:0] OP_NOP = 4'b0000;
   localparam logic [OP_W-1:0] OP_LDA = 4'b0001;
   localparam logic [OP_W-1:0] OP_ADD = 4'b0010;
   localparam logic [OP_W-1:0] OP_SUB = 4'b0011;
   localparam logic [OP_W-1:0] OP_STA = 4'b0100;
   localparam logic [OP_W-1:0] OP_LDI = 4'b0101;
   localparam logic [OP_W-1:0] OP_JMP = 4'b0110;
   localparam logic [OP_W-1:0] OP_JC  = 4'b0111;
   localparam logic [OP_W-1:0] OP_JZ  = 4'b1000;
   localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
   localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

   // Control word bit indices, HLT is the MSB and FI the LSB.
   localparam int CTRL_HLT = 15;
   localparam int CTRL_MI  = 14;
   localparam int CTRL_WE  = 13;
   localparam int CTRL_RO  = 12;
   localparam int CTRL_IO  = 11;
   localparam int CTRL_II  = 10;
   localparam int CTRL_AI  = 9;
   localparam int CTRL_AO  = 8;
   localparam int CTRL_EO  = 7;
   localparam int CTRL_SU  = 6;
   localparam int CTRL_BI  = 5;
   localparam int CTRL_OI  = 4;
   localparam int CTRL_CE  = 3;
   localparam int CTRL_CO  = 2;
   localparam int CTRL_J   = 1;
   localparam int CTRL_FI  = 0;

   typedef enum logic [STEP_W-1:0] {
      T0 = 3'd0,
      T1 = 3'd1,
      T2 = 3'd2,
      T3 = 3'd3,
      T4 = 3'd4
   } step_e;

   localparam step_e LAST_SHORT = T2;
   localparam step_e LAST_MEM   = T3;
   localparam step_e LAST_ALU   = T4;

   function automatic step_e last_step_of(input logic [OP_W-1:0] op);
      case (op)
         OP_LDA, OP_STA: last_step_of = LAST_MEM;
         OP_ADD, OP_SUB: last_step_of = LAST_ALU;
         default:        last_step_of = LAST_SHORT;
      endcase
   endfunction

endpackage

// File: rtl/control_sequencer_microcode_rom.sv
// Combinational microcode lookup: {opcode, step, flags} -> control word and
// the final T-state of the current opcode.
module microcode_rom
   import control_sequencer_pkg::*;
(
   input  logic [OP_W-1:0]   opcode,
   input  step_e             step,
   input  logic              carry_flag,
   input  logic              zero_flag,
   output logic [CTRL_W-1:0] ctrl,
   output step_e             last_step
);

   always_comb begin
      ctrl      = '0;
      last_step = last_step_of(opcode);
      case (step)
         T0: begin
            ctrl[CTRL_MI] = 1'b1;
            ctrl[CTRL_CO] = 1'b1;
         end
         T1: begin
            ctrl[CTRL_RO] = 1'b1;
            ctrl[CTRL_II] = 1'b1;
            ctrl[CTRL_CE] = 1'b1;
         end
         T2: begin
            case (opcode)
               OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_MI] = 1'b1;
               end
               OP_LDI: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_AI] = 1'b1;
               end
               OP_JMP: begin
                  ctrl[CTRL_IO] = 1'b1;
                  ctrl[CTRL_J]  = 1'b1;
               end
               // Flags only matter here; an untaken jump is a dead T2.
               OP_JC: begin
                  ctrl[CTRL_IO] = carry_flag;
                  ctrl[CTRL_J]  = carry_flag;
               end
               OP_JZ: begin
                  ctrl[CTRL_IO] = zero_flag;
                  ctrl[CTRL_J]  = zero_flag;
               end
               OP_OUT: begin
                  ctrl[CTRL_AO] = 1'b1;
                  ctrl[CTRL_OI] = 1'b1;
               end
               OP_HLT: ctrl[CTRL_HLT] = 1'b1;
               default: ;
            endcase
         end
         T3: begin
            case (opcode)
               OP_LDA: begin
                  ctrl[CTRL_RO] = 1'b1;
                  ctrl[CTRL_AI] = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  ctrl[CTRL_RO] = 1'b1;
                  ctrl[CTRL_BI] = 1'b1;
               end
               OP_STA: begin
                  ctrl[CTRL_AO] = 1'b1;
                  ctrl[CTRL_WE] = 1'b1;
               end
               default: ;
            endcase
         end
         T4: begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
               ctrl[CTRL_EO] = 1'b1;
               ctrl[CTRL_AI] = 1'b1;
               ctrl[CTRL_FI] = 1'b1;
               ctrl[CTRL_SU] = (opcode == OP_SUB);
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/control_sequencer.sv
// T-state counter, halt latch and run gating around the microcode ROM.
// ctrl is decoded combinationally and forced to zero while rst is low.
module control_sequencer
   import control_sequencer_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               run,
   input  logic [OP_W-1:0]    opcode,
   input  logic               carry_flag,
   input  logic               zero_flag,
   output logic [CTRL_W-1:0]  ctrl,
   output logic [STEP_W-1:0]  step,
   output logic               halted
);

   step_e             step_q;
   logic              halted_q;
   logic [CTRL_W-1:0] rom_ctrl;
   step_e             last_step;
   logic              step_illegal;

   microcode_rom u_rom (
      .opcode     (opcode),
      .step       (step_q),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .ctrl       (rom_ctrl),
      .last_step  (last_step)
   );

   assign step_illegal = (step_q > T4);

   // Gating with rst here drops WE the instant reset asserts, mid-write or not.
   always_comb begin
      ctrl = '0;
      if (!rst || step_illegal) begin
         ctrl = '0;
      end else if (halted_q) begin
         ctrl[CTRL_HLT] = 1'b1;
      end else begin
         ctrl = rom_ctrl;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else if (halted_q || step_illegal) begin
         step_q <= T0;
      end else if (run) begin
         if (step_q == T2 && opcode == OP_HLT) begin
            halted_q <= 1'b1;
            step_q   <= T0;
         end else if (step_q == last_step) begin
            step_q <= T0;
         end else begin
            step_q <= step_e'(step_q + 3'd1);
         end
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: expected control words are queued
// per instruction and compared cycle by cycle against the DUT.
module tb_control_sequencer;

   localparam logic [15:0] B_HLT = 16'h8000;
   localparam logic [15:0] B_MI  = 16'h4000;
   localparam logic [15:0] B_WE  = 16'h2000;
   localparam logic [15:0] B_RO  = 16'h1000;
   localparam logic [15:0] B_IO  = 16'h0800;
   localparam logic [15:0] B_II  = 16'h0400;
   localparam logic [15:0] B_AI  = 16'h0200;
   localparam logic [15:0] B_AO  = 16'h0100;
   localparam logic [15:0] B_EO  = 16'h0080;
   localparam logic [15:0] B_SU  = 16'h0040;
   localparam logic [15:0] B_BI  = 16'h0020;
   localparam logic [15:0] B_OI  = 16'h0010;
   localparam logic [15:0] B_CE  = 16'h0008;
   localparam logic [15:0] B_CO  = 16'h0004;
   localparam logic [15:0] B_J   = 16'h0002;
   localparam logic [15:0] B_FI  = 16'h0001;

   localparam logic [15:0] FETCH0 = B_MI | B_CO;
   localparam logic [15:0] FETCH1 = B_RO | B_II | B_CE;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic [3:0]  opcode = 4'd0;
   logic        carry_flag = 1'b0;
   logic        zero_flag = 1'b0;
   logic [15:0] ctrl;
   logic [2:0]  step;
   logic        halted;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   control_sequencer dut (
      .clk        (clk),
      .rst        (rst),
      .run        (run),
      .opcode     (opcode),
      .carry_flag (carry_flag),
      .zero_flag  (zero_flag),
      .ctrl       (ctrl),
      .step       (step),
      .halted     (halted)
   );

   always #5 clk = ~clk;

   // Compares every queued word against one T-state each, then expects T0.
   task automatic drain(input string name);
      int n;
      logic [15:0] e;
      n = exp_q.size();
      for (int i = 0; i < n; i++) begin
         e = exp_q.pop_front();
         checks++;
         if (ctrl !== e) begin
            errors++;
            $display("FAIL %s t%0d ctrl: got %h expected %h", name, i, ctrl, e);
         end
         checks++;
         if (step !== 3'(i)) begin
            errors++;
            $display("FAIL %s t%0d step: got %0d expected %0d", name, i, step, i);
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (step !== 3'd0) begin
         errors++;
         $display("FAIL %s end step: got %0d expected 0", name, step);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      opcode = 4'b0010;
      run = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (ctrl !== 16'h0000) begin
         errors++;
         $display("FAIL reset ctrl: got %h expected 0000", ctrl);
      end
      checks++;
      if (step !== 3'd0) begin
         errors++;
         $display("FAIL reset step: got %0d expected 0", step);
      end
      checks++;
      if (halted !== 1'b0) begin
         errors++;
         $display("FAIL reset halted: got %b expected 0", halted);
      end
      run = 1'b0;
      rst = 1'b1;
      #1;
      checks++;
      if (ctrl !== FETCH0) begin
         errors++;
         $display("FAIL reset_release ctrl: got %h expected %h", ctrl, FETCH0);
      end
   endtask

   task automatic test_lda();
      opcode = 4'b0001;
      run = 1'b1;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_IO | B_MI);
      exp_q.push_back(B_RO | B_AI);
      drain("lda");
   endtask

   task automatic test_add_sub_sta();
      opcode = 4'b0010;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_IO | B_MI);
      exp_q.push_back(B_RO | B_BI);
      exp_q.push_back(B_EO | B_AI | B_FI);
      drain("add");
      opcode = 4'b0011;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_IO | B_MI);
      exp_q.push_back(B_RO | B_BI);
      exp_q.push_back(B_EO | B_AI | B_SU | B_FI);
      drain("sub");
      opcode = 4'b0100;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_IO | B_MI);
      exp_q.push_back(B_AO | B_WE);
      drain("sta");
   endtask

   // Single-execute-step opcodes, including undefined ones.
   task automatic test_short_ops();
      logic [3:0]  ops[6];
      logic [15:0] t2[6];
      ops = '{4'b0101, 4'b0110, 4'b1110, 4'b0000, 4'b1010, 4'b1101};
      t2  = '{B_IO | B_AI, B_IO | B_J, B_AO | B_OI, 16'h0000, 16'h0000, 16'h0000};
      for (int k = 0; k < 6; k++) begin
         opcode = ops[k];
         #1;
         exp_q.push_back(FETCH0);
         exp_q.push_back(FETCH1);
         exp_q.push_back(t2[k]);
         drain($sformatf("short_op%h", ops[k]));
      end
   endtask

   task automatic test_cond_jump();
      logic [3:0]  ops[6];
      logic        cs[6];
      logic        zs[6];
      logic [15:0] t2[6];
      ops = '{4'b0111, 4'b0111, 4'b0111, 4'b1000, 4'b1000, 4'b1000};
      cs  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      zs  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      t2  = '{B_IO | B_J, 16'h0000, 16'h0000, B_IO | B_J, 16'h0000, 16'h0000};
      for (int k = 0; k < 6; k++) begin
         opcode = ops[k];
         carry_flag = cs[k];
         zero_flag = zs[k];
         #1;
         exp_q.push_back(FETCH0);
         exp_q.push_back(FETCH1);
         exp_q.push_back(t2[k]);
         drain($sformatf("jump%0d_op%h_c%b_z%b", k, ops[k], cs[k], zs[k]));
      end
      carry_flag = 1'b0;
      zero_flag = 1'b0;
   endtask

   task automatic test_freeze();
      logic [15:0] e;
      opcode = 4'b0010;
      run = 1'b1;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_IO | B_MI);
      exp_q.push_back(B_RO | B_BI);
      exp_q.push_back(B_EO | B_AI | B_FI);
      for (int i = 0; i < 5; i++) begin
         e = exp_q.pop_front();
         if (i == 3) begin
            run = 1'b0;
            for (int h = 0; h < 4; h++) begin
               checks++;
               if (step !== 3'd3 || ctrl !== e) begin
                  errors++;
                  $display("FAIL freeze hold%0d: got step %0d ctrl %h expected step 3 ctrl %h",
                           h, step, ctrl, e);
               end
               @(posedge clk);
               @(negedge clk);
            end
            run = 1'b1;
         end
         checks++;
         if (ctrl !== e || step !== 3'(i)) begin
            errors++;
            $display("FAIL freeze t%0d: got step %0d ctrl %h expected step %0d ctrl %h",
                     i, step, ctrl, i, e);
         end
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (step !== 3'd0) begin
         errors++;
         $display("FAIL freeze end step: got %0d expected 0", step);
      end
   endtask

   task automatic test_mid_reset();
      opcode = 4'b0100;
      run = 1'b1;
      #1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if (ctrl !== (B_AO | B_WE) || step !== 3'd3) begin
         errors++;
         $display("FAIL midreset t3: got step %0d ctrl %h expected step 3 ctrl %h",
                  step, ctrl, B_AO | B_WE);
      end
      #2 rst = 1'b0;
      #1;
      checks++;
      if (ctrl !== 16'h0000) begin
         errors++;
         $display("FAIL midreset async ctrl: got %h expected 0000", ctrl);
      end
      checks++;
      if (step !== 3'd0) begin
         errors++;
         $display("FAIL midreset async step: got %0d expected 0", step);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (ctrl !== FETCH0 || step !== 3'd0) begin
         errors++;
         $display("FAIL midreset release: got step %0d ctrl %h expected step 0 ctrl %h",
                  step, ctrl, FETCH0);
      end
   endtask

   task automatic test_halt();
      opcode = 4'b1111;
      run = 1'b1;
      #1;
      exp_q.push_back(FETCH0);
      exp_q.push_back(FETCH1);
      exp_q.push_back(B_HLT);
      drain("halt_seq");
      checks++;
      if (halted !== 1'b1) begin
         errors++;
         $display("FAIL halt flag: got %b expected 1", halted);
      end
      checks++;
      if (ctrl !== B_HLT) begin
         errors++;
         $display("FAIL halt ctrl: got %h expected %h", ctrl, B_HLT);
      end
      for (int i = 0; i < 10; i++) begin
         run = 1'($urandom_range(0, 1));
         opcode = 4'($urandom_range(0, 15));
         carry_flag = 1'($urandom_range(0, 1));
         zero_flag = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (halted !== 1'b1 || ctrl !== B_HLT || step !== 3'd0) begin
            errors++;
            $display("FAIL halt hold%0d: got halted %b ctrl %h step %0d expected 1 %h 0",
                     i, halted, ctrl, step, B_HLT);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (ctrl !== 16'h0000 || halted !== 1'b0) begin
         errors++;
         $display("FAIL halt reset: got halted %b ctrl %h expected 0 0000", halted, ctrl);
      end
      @(negedge clk);
      rst = 1'b1;
      opcode = 4'b0000;
      #1;
      checks++;
      if (halted !== 1'b0 || ctrl !== FETCH0) begin
         errors++;
         $display("FAIL halt release: got halted %b ctrl %h expected 0 %h", halted, ctrl, FETCH0);
      end
   endtask

   initial begin
      test_reset();
      test_lda();
      test_add_sub_sta();
      test_short_ops();
      test_cond_jump();
      test_freeze();
      test_mid_reset();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
